// File: rtl/fmul_sched.sv
`default_nettype none
// fmul_sched: round-robin scheduler sharing one single-precision multiplier between
// NREQ requesters; each product returns to a per-requester slot held until consumed.

module fmul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic [47:0] prod;
  logic        norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        rnd;
  logic [23:0] mant_r;
  logic [7:0]  exp_s;

  always_comb begin
    prod   = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};
    norm   = prod[47];
    mant   = norm ? prod[46:24] : prod[45:23];
    guard  = norm ? prod[23] : prod[22];
    sticky = norm ? |prod[22:0] : |prod[21:0];
    // Round to nearest, ties to even; a carry out of the mantissa bumps the exponent.
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    exp_s  = a_i[30:23] + b_i[30:23] - 8'd127 + {7'd0, norm} + {7'd0, mant_r[23]};
    if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0) y_o = 32'd0;
    else                                          y_o = {a_i[31] ^ b_i[31], exp_s, mant_r[22:0]};
  end
endmodule

module fmul_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*32-1:0]   rsp_y,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 idle
);
  localparam int PW = $clog2(NREQ);
  localparam int ND = LAT - 2;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] busy_q, busy_d;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [PW:0]     rr_sum;
  logic [NREQ-1:0] consume;
  logic [NREQ-1:0] slot_set;

  logic [31:0]     op_x1_q, op_x2_q;
  logic [PW-1:0]   op_tag_q;
  logic            op_vld_q;

  logic [31:0]     mul_y;
  logic [31:0]     res_y;
  logic [PW-1:0]   res_tag;
  logic            res_vld;

  logic [31:0]     slot_y_q [NREQ];
  logic [NREQ-1:0] slot_vld_q;

  assign elig    = req_valid & ~busy_q;
  assign consume = slot_vld_q & rsp_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NREQ)) rr_sum = rr_sum - (PW+1)'(NREQ);
      if (!gnt_any && elig[rr_sum[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_sum[PW-1:0];
      end
    end
    grant = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);

    // Grant and consume never hit the same index: a busy requester is not eligible.
    busy_d = (busy_q | grant) & ~consume;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q    <= '0;
      busy_q   <= '0;
      op_x1_q  <= '0;
      op_x2_q  <= '0;
      op_tag_q <= '0;
      op_vld_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      op_vld_q <= gnt_any;
      if (gnt_any) begin
        op_x1_q  <= req_x1[32*gnt_idx +: 32];
        op_x2_q  <= req_x2[32*gnt_idx +: 32];
        op_tag_q <= gnt_idx;
      end
    end
  end

  fmul u_fmul (
    .a_i (op_x1_q),
    .b_i (op_x2_q),
    .y_o (mul_y)
  );

  generate
    if (ND == 0) begin : g_no_dly
      assign res_y   = mul_y;
      assign res_tag = op_tag_q;
      assign res_vld = op_vld_q;
    end else begin : g_dly
      logic [31:0]   dly_y_q   [ND];
      logic [PW-1:0] dly_tag_q [ND];
      logic [ND-1:0] dly_vld_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dly_vld_q <= '0;
          for (int s = 0; s < ND; s++) begin
            dly_y_q[s]   <= '0;
            dly_tag_q[s] <= '0;
          end
        end else begin
          dly_vld_q[0] <= op_vld_q;
          if (op_vld_q) begin
            dly_y_q[0]   <= mul_y;
            dly_tag_q[0] <= op_tag_q;
          end
          for (int s = 1; s < ND; s++) begin
            dly_vld_q[s] <= dly_vld_q[s-1];
            if (dly_vld_q[s-1]) begin
              dly_y_q[s]   <= dly_y_q[s-1];
              dly_tag_q[s] <= dly_tag_q[s-1];
            end
          end
        end
      end

      assign res_y   = dly_y_q[ND-1];
      assign res_tag = dly_tag_q[ND-1];
      assign res_vld = dly_vld_q[ND-1];
    end
  endgenerate

  assign slot_set = res_vld ? (NREQ'(1) << res_tag) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_vld_q <= '0;
      for (int i = 0; i < NREQ; i++) slot_y_q[i] <= '0;
    end else begin
      slot_vld_q <= (slot_vld_q & ~consume) | slot_set;
      if (res_vld) slot_y_q[res_tag] <= res_y;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign rsp_y[32*gi +: 32] = slot_y_q[gi];
    end
  endgenerate

  assign req_ready = grant;
  assign rsp_valid = slot_vld_q;
  assign idle      = ~|busy_q;

endmodule
`default_nettype wire
